board_store: RTL and testbench

- Playfield owner for the Tetris datapath; the other end of the piece generator/mover handshake.
- Holds the 10x12 occupancy board and drives it as row vectors arr0..arr11 to the mover.
- Requests each new piece (gen_flag) and locks the four landed cells when bottom_flag is raised.
- Clears full rows, counts cleared lines, detects game over, and returns to idle on Ack.

---
 rtl/board_store.sv | 214 +++++++++++++++++++++
 tb/tb_board_store.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_store.sv
// Tetris playfield: 10x12 occupancy board, piece lock, row clearing, line count, game over.
// Optional macro LOCK_OVERLAP_CHECK_EN adds the sticky overlap_err output.
module board_store #(
  parameter int LINE_W    = 8,
  parameter int SPAWN_GAP = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Ack,
  input  logic              bottom_flag,
  input  logic              top_flag,
  input  logic [3:0]        x1,
  input  logic [3:0]        y1,
  input  logic [3:0]        x2,
  input  logic [3:0]        y2,
  input  logic [3:0]        x3,
  input  logic [3:0]        y3,
  input  logic [3:0]        x4,
  input  logic [3:0]        y4,
  output logic [9:0]        arr0,
  output logic [9:0]        arr1,
  output logic [9:0]        arr2,
  output logic [9:0]        arr3,
  output logic [9:0]        arr4,
  output logic [9:0]        arr5,
  output logic [9:0]        arr6,
  output logic [9:0]        arr7,
  output logic [9:0]        arr8,
  output logic [9:0]        arr9,
  output logic [9:0]        arr10,
  output logic [9:0]        arr11,
  output logic              gen_flag,
  output logic [LINE_W-1:0] lines,
  output logic              game_over,
  output logic [2:0]        state
`ifdef LOCK_OVERLAP_CHECK_EN
  ,
  output logic              overlap_err
`endif
);

  localparam int GAP_W = (SPAWN_GAP < 2) ? 1 : $clog2(SPAWN_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_PLAY  = 3'd2,
    S_LOCK  = 3'd3,
    S_SCAN  = 3'd4,
    S_GAP   = 3'd5,
    S_OVER  = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [11:0][9:0]    board_q, board_d;
  logic [3:0]          r_q, r_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [LINE_W-1:0]   lines_q, lines_d;
  logic                over_pend_q, over_pend_d;
  logic                gen_flag_q;
  logic                game_over_q;
`ifdef LOCK_OVERLAP_CHECK_EN
  logic                overlap_q, overlap_d;
`endif

  logic [3:0] xs_s [4];
  logic [3:0] ys_s [4];

  assign xs_s[0] = x1;
  assign xs_s[1] = x2;
  assign xs_s[2] = x3;
  assign xs_s[3] = x4;
  assign ys_s[0] = y1;
  assign ys_s[1] = y2;
  assign ys_s[2] = y3;
  assign ys_s[3] = y4;

  function automatic logic cell_ok(input logic [3:0] x, input logic [3:0] y);
    return (x <= 4'd9) && (y <= 4'd11);
  endfunction

  // Next-state, board update, row clearing and counters
  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    r_d         = r_q;
    gap_d       = gap_q;
    lines_d     = lines_q;
    over_pend_d = over_pend_q;
`ifdef LOCK_OVERLAP_CHECK_EN
    overlap_d   = overlap_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) state_d = S_SPAWN;
        else       state_d = S_IDLE;
      end
      S_SPAWN: state_d = S_PLAY;
      S_PLAY: begin
        if (bottom_flag) state_d = S_LOCK;
        else             state_d = S_PLAY;
      end
      S_LOCK: begin
        // Out-of-range cells are dropped; occupancy is tested against the pre-lock board
        for (int k = 0; k < 4; k++) begin
          if (cell_ok(xs_s[k], ys_s[k])) begin
`ifdef LOCK_OVERLAP_CHECK_EN
            if (board_q[ys_s[k]][xs_s[k]]) overlap_d = 1'b1;
            else                           overlap_d = overlap_d;
`endif
            board_d[ys_s[k]][xs_s[k]] = 1'b1;
          end else begin
`ifdef LOCK_OVERLAP_CHECK_EN
            overlap_d = 1'b1;
`endif
          end
        end
        over_pend_d = top_flag;
        r_d         = 4'd0;
        state_d     = S_SCAN;
      end
      S_SCAN: begin
        if (board_q[r_q] == 10'h3FF) begin
          // r holds so the row dropped into place is rechecked next cycle
          for (int i = 0; i < 11; i++) begin
            if (4'(i) >= r_q) board_d[i] = board_q[i+1];
            else              board_d[i] = board_q[i];
          end
          board_d[11] = 10'h000;
          if (lines_q != {LINE_W{1'b1}}) lines_d = lines_q + LINE_W'(1);
          else                           lines_d = lines_q;
        end else if (r_q == 4'd11) begin
          gap_d   = GAP_W'(SPAWN_GAP);
          state_d = S_GAP;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      S_GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          if (over_pend_q) state_d = S_OVER;
          else             state_d = S_SPAWN;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      S_OVER: begin
        if (Ack) begin
          board_d     = '0;
          lines_d     = '0;
          over_pend_d = 1'b0;
`ifdef LOCK_OVERLAP_CHECK_EN
          overlap_d   = 1'b0;
`endif
          state_d     = S_IDLE;
        end else begin
          state_d = S_OVER;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; gen_flag/game_over registered from the next state
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      board_q     <= '0;
      r_q         <= 4'd0;
      gap_q       <= '0;
      lines_q     <= '0;
      over_pend_q <= 1'b0;
      gen_flag_q  <= 1'b0;
      game_over_q <= 1'b0;
`ifdef LOCK_OVERLAP_CHECK_EN
      overlap_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      r_q         <= r_d;
      gap_q       <= gap_d;
      lines_q     <= lines_d;
      over_pend_q <= over_pend_d;
      gen_flag_q  <= (state_d == S_SPAWN);
      game_over_q <= (state_d == S_OVER);
`ifdef LOCK_OVERLAP_CHECK_EN
      overlap_q   <= overlap_d;
`endif
    end
  end

  assign arr0      = board_q[0];
  assign arr1      = board_q[1];
  assign arr2      = board_q[2];
  assign arr3      = board_q[3];
  assign arr4      = board_q[4];
  assign arr5      = board_q[5];
  assign arr6      = board_q[6];
  assign arr7      = board_q[7];
  assign arr8      = board_q[8];
  assign arr9      = board_q[9];
  assign arr10     = board_q[10];
  assign arr11     = board_q[11];
  assign gen_flag  = gen_flag_q;
  assign lines     = lines_q;
  assign game_over = game_over_q;
  assign state     = state_q;
`ifdef LOCK_OVERLAP_CHECK_EN
  assign overlap_err = overlap_q;
`endif

endmodule

// File: tb/tb_board_store.sv
// Scoreboard bench for board_store: expected board/lines snapshots are queued per lock and
// compared by a monitor at every gen_flag pulse and on the rising edge of game_over.
module tb_board_store;

  localparam int GAP = 2;

  logic       Clk = 1'b0;
  logic       Reset_n, Start, Ack, bottom_flag, top_flag;
  logic [3:0] x1, y1, x2, y2, x3, y3, x4, y4;
  logic [9:0] arr0, arr1, arr2, arr3, arr4, arr5, arr6, arr7, arr8, arr9, arr10, arr11;
  logic       gen_flag, game_over;
  logic [7:0] lines;
  logic [2:0] state;
`ifdef LOCK_OVERLAP_CHECK_EN
  logic       overlap_err;
`endif

  board_store #(.LINE_W(8), .SPAWN_GAP(GAP)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack),
    .bottom_flag(bottom_flag), .top_flag(top_flag),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3), .x4(x4), .y4(y4),
    .arr0(arr0), .arr1(arr1), .arr2(arr2), .arr3(arr3), .arr4(arr4), .arr5(arr5),
    .arr6(arr6), .arr7(arr7), .arr8(arr8), .arr9(arr9), .arr10(arr10), .arr11(arr11),
    .gen_flag(gen_flag), .lines(lines), .game_over(game_over), .state(state)
`ifdef LOCK_OVERLAP_CHECK_EN
    , .overlap_err(overlap_err)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic             over;
    logic [11:0][9:0] rows;
    logic [7:0]       lines;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [11:0][9:0] act_rows;
  int               checks = 0;
  int               errors = 0;
  logic             go_prev = 1'b0;
  logic             gen_prev = 1'b0;
  int               scan_n, gap_n;

  assign act_rows = {arr11, arr10, arr9, arr8, arr7, arr6, arr5, arr4, arr3, arr2, arr1, arr0};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic ov, input logic [7:0] ln, input logic [9:0] r0,
                      input logic [9:0] r1, input logic [9:0] r2, input logic [9:0] r3,
                      input logic [9:0] r11);
    exp_t e;
    e          = '0;
    e.over     = ov;
    e.lines    = ln;
    e.rows[0]  = r0;
    e.rows[1]  = r1;
    e.rows[2]  = r2;
    e.rows[3]  = r3;
    e.rows[11] = r11;
    exp_q.push_back(e);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge Clk);
      n++;
    end
    chk("wait_state", {125'd0, state}, {125'd0, s});
  endtask

  // xy = {x1,y1,x2,y2,x3,y3,x4,y4}; returns after the first SCAN cycle when stop_scan is set
  task automatic lock_piece(input logic [31:0] xy, input logic top, input bit stop_scan,
                            output int sn, output int gn);
    sn = 0;
    gn = 0;
    wait_state(3'd2, 60);
    {x1, y1, x2, y2, x3, y3, x4, y4} = xy;
    top_flag    = top;
    bottom_flag = 1'b1;
    @(negedge Clk);
    chk("enter_lock", {125'd0, state}, 128'd3);
    @(negedge Clk);
    bottom_flag = 1'b0;
    top_flag    = 1'b0;
    if (!stop_scan) begin
      while (state === 3'd4 && sn < 40) begin
        sn++;
        @(negedge Clk);
      end
      while (state === 3'd5 && gn < 10) begin
        gn++;
        @(negedge Clk);
      end
    end
  endtask

  // Scoreboard monitor: snapshot compare on each new-piece request or game-over entry
  always @(negedge Clk) begin
    if (!Reset_n) begin
      go_prev  <= 1'b0;
      gen_prev <= 1'b0;
    end else begin
      if (gen_flag || (game_over && !go_prev)) begin
        if (gen_flag) chk("gen_width", {127'd0, gen_prev}, 128'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: gen_flag=%0b game_over=%0b with no expectation", gen_flag, game_over);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_game_over", {127'd0, game_over}, {127'd0, mon_e.over});
          chk("sb_lines", {120'd0, lines}, {120'd0, mon_e.lines});
          for (int i = 0; i < 12; i++)
            chk($sformatf("sb_arr%0d", i), {118'd0, act_rows[i]}, {118'd0, mon_e.rows[i]});
        end
      end
      go_prev  <= game_over;
      gen_prev <= gen_flag;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; Start = 1'b0; Ack = 1'b0; bottom_flag = 1'b0; top_flag = 1'b0;
    {x1, y1, x2, y2, x3, y3, x4, y4} = 32'h0;
    repeat (2) @(negedge Clk);
    chk("rst_state", {125'd0, state}, 128'd0);
    chk("rst_gen", {127'd0, gen_flag}, 128'd0);
    chk("rst_lines", {120'd0, lines}, 128'd0);
    chk("rst_over", {127'd0, game_over}, 128'd0);
    chk("rst_board", {8'd0, act_rows}, 128'd0);
`ifdef LOCK_OVERLAP_CHECK_EN
    chk("rst_overlap", {127'd0, overlap_err}, 128'd0);
`endif
    Reset_n = 1'b1;
    @(negedge Clk);

    // Start: gen_flag in the cycle after Start is sampled, then PLAY
    push(1'b0, 8'd0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0);
    Start = 1'b1;
    @(negedge Clk);
    chk("spawn_state", {125'd0, state}, 128'd1);
    chk("spawn_gen", {127'd0, gen_flag}, 128'd1);
    Start = 1'b0;
    @(negedge Clk);
    chk("play_state", {125'd0, state}, 128'd2);
    chk("play_gen", {127'd0, gen_flag}, 128'd0);

    push(1'b0, 8'd0, 10'h0F0, 10'h0, 10'h0, 10'h0, 10'h0);
    lock_piece(32'h4050_6070, 1'b0, 1'b0, scan_n, gap_n);
    chk("scan_cycles_12", scan_n, 128'd12);
    chk("gap_cycles", gap_n, GAP);
    push(1'b0, 8'd0, 10'h0FF, 10'h0, 10'h0, 10'h0, 10'h0);
    lock_piece(32'h0010_2030, 1'b0, 1'b0, scan_n, gap_n);
    push(1'b0, 8'd0, 10'h1FF, 10'h007, 10'h0, 10'h0, 10'h0);
    lock_piece(32'h8001_1121, 1'b0, 1'b0, scan_n, gap_n);
    push(1'b0, 8'd0, 10'h1FF, 10'h07F, 10'h0, 10'h0, 10'h0);
    lock_piece(32'h3141_5161, 1'b0, 1'b0, scan_n, gap_n);
    push(1'b0, 8'd0, 10'h1FF, 10'h1FF, 10'h001, 10'h020, 10'h0);
    lock_piece(32'h7181_0253, 1'b0, 1'b0, scan_n, gap_n);
`ifdef LOCK_OVERLAP_CHECK_EN
    chk("overlap_clean", {127'd0, overlap_err}, 128'd0);
`endif
    // Out-of-range cells dropped, duplicate of an occupied cell harmless
    push(1'b0, 8'd0, 10'h1FF, 10'h1FF, 10'h001, 10'h020, 10'h0);
    lock_piece(32'hA22C_FF02, 1'b0, 1'b0, scan_n, gap_n);
`ifdef LOCK_OVERLAP_CHECK_EN
    chk("overlap_set", {127'd0, overlap_err}, 128'd1);
`endif
    // Vertical bar completes rows 0 and 1: two clears at r=0
    push(1'b0, 8'd2, 10'h201, 10'h220, 10'h0, 10'h0, 10'h0);
    lock_piece(32'h9091_9293, 1'b0, 1'b0, scan_n, gap_n);
    chk("scan_cycles_14", scan_n, 128'd14);

    // top_flag: no respawn, OVER holds the final board
    push(1'b1, 8'd2, 10'h201, 10'h220, 10'h0, 10'h0, 10'h00F);
    lock_piece(32'h0B1B_2B3B, 1'b1, 1'b0, scan_n, gap_n);
    Start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("over_state", {125'd0, state}, 128'd6);
      chk("over_flag", {127'd0, game_over}, 128'd1);
      chk("over_nogen", {127'd0, gen_flag}, 128'd0);
      chk("over_lines", {120'd0, lines}, 128'd2);
      @(negedge Clk);
    end
`ifdef LOCK_OVERLAP_CHECK_EN
    chk("overlap_held", {127'd0, overlap_err}, 128'd1);
`endif
    // Ack and Start together: Ack wins, Start honoured next cycle
    push(1'b0, 8'd0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0);
    Ack = 1'b1;
    @(negedge Clk);
    chk("ack_state", {125'd0, state}, 128'd0);
    chk("ack_board", {8'd0, act_rows}, 128'd0);
    chk("ack_lines", {120'd0, lines}, 128'd0);
    chk("ack_over", {127'd0, game_over}, 128'd0);
`ifdef LOCK_OVERLAP_CHECK_EN
    chk("overlap_ack", {127'd0, overlap_err}, 128'd0);
`endif
    Ack = 1'b0;
    @(negedge Clk);
    chk("restart_state", {125'd0, state}, 128'd1);
    Start = 1'b0;

    // Build arr0=30F, arr1=001, then complete row 0
    push(1'b0, 8'd0, 10'h00F, 10'h0, 10'h0, 10'h0, 10'h0);
    lock_piece(32'h0010_2030, 1'b0, 1'b0, scan_n, gap_n);
    push(1'b0, 8'd0, 10'h30F, 10'h001, 10'h0, 10'h0, 10'h0);
    lock_piece(32'h8090_0180, 1'b0, 1'b0, scan_n, gap_n);
    push(1'b0, 8'd1, 10'h001, 10'h000, 10'h0, 10'h0, 10'h0);
    lock_piece(32'h4050_6070, 1'b0, 1'b0, scan_n, gap_n);
    chk("scan_cycles_13", scan_n, 128'd13);
    push(1'b0, 8'd1, 10'h01F, 10'h0, 10'h0, 10'h0, 10'h0);
    lock_piece(32'h1020_3040, 1'b0, 1'b0, scan_n, gap_n);
    push(1'b0, 8'd1, 10'h1FF, 10'h0, 10'h0, 10'h0, 10'h0);
    lock_piece(32'h5060_7080, 1'b0, 1'b0, scan_n, gap_n);

    // Reset asserted in the SCAN cycle that is shifting a full row
    lock_piece(32'h9090_9090, 1'b0, 1'b1, scan_n, gap_n);
    chk("pre_rst_state", {125'd0, state}, 128'd4);
    chk("pre_rst_row0", {118'd0, arr0}, 128'h3FF);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_state", {125'd0, state}, 128'd0);
    chk("async_rst_board", {8'd0, act_rows}, 128'd0);
    chk("async_rst_lines", {120'd0, lines}, 128'd0);
    chk("async_rst_gen", {127'd0, gen_flag}, 128'd0);
    chk("async_rst_over", {127'd0, game_over}, 128'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    chk("post_rst_idle", {125'd0, state}, 128'd0);
    chk("sb_drained", exp_q.size(), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
